cell_packet_forwarder: RTL and testbench

CELL_PACKET_FORWARDER -- requirements
Module: cell_packet_forwarder

---
 rtl/cell_packet_forwarder.sv | 163 ++++++++++++++++
 tb/tb_cell_packet_forwarder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cell_packet_forwarder.sv
// Queues accepted cell/BPM packets (hop decremented, hop-0 and overflow dropped) and re-emits them as
// rate-limited one-cycle strobes; 2-cycle latency into an empty FIFO, strobes at least GAP cycles apart.
module cell_packet_forwarder #(
   parameter int FIFO_AW = 2,
   parameter int GAP     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [1:0]         in_src,
   input  logic [31:0]        in_header,
   input  logic [31:0]        in_datax,
   input  logic [31:0]        in_datay,
   input  logic [31:0]        in_datas,
   input  logic               enable,
   input  logic               clear_counts,
   output logic               out_strobe,
   output logic [1:0]         out_sel,
   output logic [31:0]        out_header,
   output logic [31:0]        out_datax,
   output logic [31:0]        out_datay,
   output logic [31:0]        out_datas,
   output logic [FIFO_AW:0]   fifo_level,
   output logic [15:0]        drop_ttl_count,
   output logic [15:0]        drop_full_count
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int EW    = 2 + 4 * 32;
   localparam logic [3:0]         GAP_LOAD = 4'(GAP - 1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);

   logic [EW-1:0]      mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic [3:0]         gap_q, gap_d;
   logic [15:0]        ttl_q, ttl_d;
   logic [15:0]        full_q, full_d;
   logic               strobe_q, strobe_d;
   logic [1:0]         sel_q, sel_d;
   logic [31:0]        hdr_q, hdr_d;
   logic [31:0]        dx_q, dx_d;
   logic [31:0]        dy_q, dy_d;
   logic [31:0]        ds_q, ds_d;

   logic [7:0]    hop;
   logic          accept;
   logic          is_full;
   logic          push;
   logic          pop;
   logic          ttl_drop;
   logic          full_drop;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] rd_entry;

   assign hop       = in_header[7:0];
   assign accept    = in_valid & enable;
   // level can never exceed DEPTH, so its MSB alone marks a full FIFO
   assign is_full   = level_q[FIFO_AW];
   assign ttl_drop  = accept && (hop == 8'd0);
   assign full_drop = accept && (hop != 8'd0) && is_full;
   assign push      = accept && (hop != 8'd0) && !is_full;
   assign pop       = (level_q != '0) && (gap_q == 4'd0);
   assign wr_entry  = {in_src, in_header[31:8], hop - 8'd1, in_datax, in_datay, in_datas};
   assign rd_entry  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_ONE;
      end else if (!push && pop) begin
         level_d = level_q - LVL_ONE;
      end

      gap_d = gap_q;
      if (pop) begin
         gap_d = GAP_LOAD;
      end else if (gap_q != 4'd0) begin
         gap_d = gap_q - 4'd1;
      end

      ttl_d  = ttl_q;
      full_d = full_q;
      if (clear_counts) begin
         ttl_d  = 16'd0;
         full_d = 16'd0;
      end else begin
         if (ttl_drop && (ttl_q != 16'hFFFF)) begin
            ttl_d = ttl_q + 16'd1;
         end
         if (full_drop && (full_q != 16'hFFFF)) begin
            full_d = full_q + 16'd1;
         end
      end

      // output words only change on a pop so they stay stable between strobes
      strobe_d = pop;
      sel_d    = sel_q;
      hdr_d    = hdr_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      ds_d     = ds_q;
      if (pop) begin
         sel_d = rd_entry[129:128];
         hdr_d = rd_entry[127:96];
         dx_d  = rd_entry[95:64];
         dy_d  = rd_entry[63:32];
         ds_d  = rd_entry[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         gap_q    <= 4'd0;
         ttl_q    <= 16'd0;
         full_q   <= 16'd0;
         strobe_q <= 1'b0;
         sel_q    <= 2'd0;
         hdr_q    <= 32'd0;
         dx_q     <= 32'd0;
         dy_q     <= 32'd0;
         ds_q     <= 32'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         gap_q    <= gap_d;
         ttl_q    <= ttl_d;
         full_q   <= full_d;
         strobe_q <= strobe_d;
         sel_q    <= sel_d;
         hdr_q    <= hdr_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         ds_q     <= ds_d;
      end
   end

   assign out_strobe      = strobe_q;
   assign out_sel         = sel_q;
   assign out_header      = hdr_q;
   assign out_datax       = dx_q;
   assign out_datay       = dy_q;
   assign out_datas       = ds_q;
   assign fifo_level      = level_q;
   assign drop_ttl_count  = ttl_q;
   assign drop_full_count = full_q;

endmodule

// File: tb/tb_cell_packet_forwarder.sv
// Directed bench with a strobe scoreboard: stimulus pushes expected packets, a negedge monitor pops and compares.
module tb_cell_packet_forwarder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_src;
   logic [31:0] in_header, in_datax, in_datay, in_datas;
   logic        enable;
   logic        clear_counts;
   logic        out_strobe;
   logic [1:0]  out_sel;
   logic [31:0] out_header, out_datax, out_datay, out_datas;
   logic [2:0]  fifo_level;
   logic [15:0] drop_ttl_count, drop_full_count;

   cell_packet_forwarder #(.FIFO_AW(2), .GAP(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_src          (in_src),
      .in_header       (in_header),
      .in_datax        (in_datax),
      .in_datay        (in_datay),
      .in_datas        (in_datas),
      .enable          (enable),
      .clear_counts    (clear_counts),
      .out_strobe      (out_strobe),
      .out_sel         (out_sel),
      .out_header      (out_header),
      .out_datax       (out_datax),
      .out_datay       (out_datay),
      .out_datas       (out_datas),
      .fifo_level      (fifo_level),
      .drop_ttl_count  (drop_ttl_count),
      .drop_full_count (drop_full_count)
   );

   typedef struct {
      int          cyc;
      logic [1:0]  sel;
      logic [31:0] hdr;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] s;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && out_strobe) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL strobe_unexpected: got strobe sel=%0d hdr=%h at cyc %0d, expected no strobe",
                     out_sel, out_header, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (out_sel !== e.sel || out_header !== e.hdr || out_datax !== e.x ||
                out_datay !== e.y || out_datas !== e.s || (e.cyc >= 0 && cyc != e.cyc)) begin
               miscompares++;
               $display("FAIL strobe_pkt: got sel=%0d hdr=%h x=%h y=%h s=%h cyc=%0d, expected sel=%0d hdr=%h x=%h y=%h s=%h cyc=%0d",
                        out_sel, out_header, out_datax, out_datay, out_datas, cyc,
                        e.sel, e.hdr, e.x, e.y, e.s, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pkt(input logic en, input logic [1:0] src, input logic [31:0] hdr,
                      input logic [31:0] x, input logic [31:0] y, input logic [31:0] s);
      @(negedge clk);
      enable    = en;
      in_valid  = 1'b1;
      in_src    = src;
      in_header = hdr;
      in_datax  = x;
      in_datay  = y;
      in_datas  = s;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expect_pkt(input int c, input logic [1:0] sel, input logic [31:0] hdr,
                             input logic [31:0] x, input logic [31:0] y, input logic [31:0] s);
      exp_t e;
      e.cyc = c; e.sel = sel; e.hdr = hdr; e.x = x; e.y = y; e.s = s;
      sb.push_back(e);
   endtask

   logic [1:0]  fill_src [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
   logic [31:0] fill_hdr [6] = '{32'hA1000005, 32'hA2000005, 32'hA3000005,
                                 32'hA4000005, 32'hA5000005, 32'hA6000005};
   logic [31:0] fill_exp [6] = '{32'hA1000004, 32'hA2000004, 32'hA3000004,
                                 32'hA4000004, 32'hA5000004, 32'hA6000004};

   initial begin
      int t0;
      rst = 1'b1; in_valid = 1'b0; in_src = 2'd0; enable = 1'b1; clear_counts = 1'b0;
      in_header = 32'd0; in_datax = 32'd0; in_datay = 32'd0; in_datas = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_strobe", 32'(out_strobe), 32'd0);
      chk("rst_level",  32'(fifo_level), 32'd0);
      chk("rst_ttl",    32'(drop_ttl_count), 32'd0);
      chk("rst_full",   32'(drop_full_count), 32'd0);
      chk("rst_header", out_header, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single packet latency
      pkt(1'b1, 2'd0, 32'h12340005, 32'h00000011, 32'h00000022, 32'h00000033);
      t0 = cyc;
      expect_pkt(t0 + 2, 2'd0, 32'h12340004, 32'h00000011, 32'h00000022, 32'h00000033);
      idle();
      repeat (10) @(negedge clk);
      chk("single_drained", 32'(sb.size()), 32'd0);

      // hop 0 dropped
      pkt(1'b1, 2'd1, 32'hABCD0000, 32'h1, 32'h2, 32'h3);
      idle();
      chk("ttl_drop_count", 32'(drop_ttl_count), 32'd1);
      chk("ttl_drop_level", 32'(fifo_level), 32'd0);
      repeat (8) @(negedge clk);

      // six back-to-back packets into a 4-deep FIFO
      for (int i = 0; i < 6; i++) begin
         pkt(1'b1, fill_src[i], fill_hdr[i], 32'h100 + i, 32'h200 + i, 32'h300 + i);
         if (i == 0) t0 = cyc;
         if (i < 5) expect_pkt(t0 + 2 + 4 * i, fill_src[i], fill_exp[i], 32'h100 + i, 32'h200 + i, 32'h300 + i);
         if (i == 5) chk("fill_level_full", 32'(fifo_level), 32'd4);
      end
      idle();
      chk("fill_full_drop", 32'(drop_full_count), 32'd1);
      repeat (25) @(negedge clk);
      chk("fill_drained", 32'(sb.size()), 32'd0);
      chk("fill_level_end", 32'(fifo_level), 32'd0);

      // reset mid-operation discards queued packets
      for (int i = 0; i < 4; i++) begin
         pkt(1'b1, 2'd3, 32'hC0DE0007 + (i << 8), 32'h400 + i, 32'h500 + i, 32'h600 + i);
         if (i == 0) begin
            t0 = cyc;
            expect_pkt(t0 + 2, 2'd3, 32'hC0DE0006, 32'h400, 32'h500, 32'h600);
         end
      end
      idle();
      chk("prerst_level", 32'(fifo_level), 32'd3);
      rst = 1'b1;
      #1;
      chk("midrst_level",  32'(fifo_level), 32'd0);
      chk("midrst_header", out_header, 32'd0);
      chk("midrst_datax",  out_datax, 32'd0);
      chk("midrst_ttl",    32'(drop_ttl_count), 32'd0);
      chk("midrst_full",   32'(drop_full_count), 32'd0);
      repeat (2) @(negedge clk);
      chk("midrst_strobe", 32'(out_strobe), 32'd0);
      rst = 1'b0;
      pkt(1'b1, 2'd2, 32'h77770002, 32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC);
      t0 = cyc;
      expect_pkt(t0 + 2, 2'd2, 32'h77770001, 32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC);
      idle();
      repeat (20) @(negedge clk);
      chk("postrst_drained", 32'(sb.size()), 32'd0);

      // enable=0 ignores new packets but keeps draining
      pkt(1'b1, 2'd0, 32'h00000000, 32'h0, 32'h0, 32'h0);
      idle();
      pkt(1'b1, 2'd1, 32'h5A5A5A03, 32'hD1, 32'hD2, 32'hD3);
      t0 = cyc;
      expect_pkt(t0 + 2, 2'd1, 32'h5A5A5A02, 32'hD1, 32'hD2, 32'hD3);
      pkt(1'b1, 2'd2, 32'h6B6B6B01, 32'hE1, 32'hE2, 32'hE3);
      expect_pkt(t0 + 6, 2'd2, 32'h6B6B6B00, 32'hE1, 32'hE2, 32'hE3);
      pkt(1'b0, 2'd3, 32'h11111105, 32'hF1, 32'hF2, 32'hF3);
      pkt(1'b0, 2'd0, 32'h22222200, 32'hF4, 32'hF5, 32'hF6);
      pkt(1'b0, 2'd1, 32'h33333309, 32'hF7, 32'hF8, 32'hF9);
      pkt(1'b0, 2'd2, 32'h44444400, 32'hFA, 32'hFB, 32'hFC);
      idle();
      repeat (20) @(negedge clk);
      chk("dis_drained", 32'(sb.size()), 32'd0);
      chk("dis_level",   32'(fifo_level), 32'd0);
      chk("dis_ttl",     32'(drop_ttl_count), 32'd1);
      chk("dis_full",    32'(drop_full_count), 32'd0);
      enable = 1'b1;

      // saturation and clear priority
      @(negedge clk);
      clear_counts = 1'b1;
      @(negedge clk);
      clear_counts = 1'b0;
      chk("clr_ttl", 32'(drop_ttl_count), 32'd0);
      in_header = 32'hABCD0000;
      in_valid  = 1'b1;
      repeat (65534) @(negedge clk);
      in_valid = 1'b0;
      chk("sat_fffe", 32'(drop_ttl_count), 32'h0000FFFE);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk("sat_hold", 32'(drop_ttl_count), 32'h0000FFFF);
      in_valid = 1'b1;
      clear_counts = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      clear_counts = 1'b0;
      chk("clr_priority", 32'(drop_ttl_count), 32'd0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ttl_after_clr", 32'(drop_ttl_count), 32'd1);

      repeat (10) @(negedge clk);
      chk("final_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
